noc_inject_arbiter: RTL and testbench

NOC_INJECT_ARBITER -- requirements
Module: noc_inject_arbiter

---
 rtl/noc_flit_pkg.sv | 24 ++
 rtl/noc_credit_counter.sv | 36 +++
 rtl/noc_inject_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_noc_inject_arbiter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_flit_pkg.sv
// Shared definitions for the NoC injection path.
// Contents:
//   FLIT_*_OFS  - control-field positions, as offsets from the flit MSB
//                 (bit = WIDTH - offset), so they hold for any flit width
//   arb_state_e - injection arbiter FSM state
//   safe_clog2  - clog2 that never returns 0, so 1-entry fields keep one bit
package noc_flit_pkg;

  localparam int FLIT_VALID_OFS = 1;
  localparam int FLIT_HEAD_OFS  = 2;
  localparam int FLIT_TAIL_OFS  = 3;
  // MSB of the VC field; dest and payload sit directly below it.
  localparam int FLIT_VC_OFS    = 4;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  function automatic int safe_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/noc_credit_counter.sv
// Credit counter for one virtual channel.
// Ports:
//   clk, reset - clock, asynchronous active-high reset (count -> VC_DEPTH)
//   dec        - a flit was sent on this VC this cycle
//   inc        - credit-return pulse from the router
//   count      - credits currently available, 0..VC_DEPTH
//   overflow   - credit returned while already full (count saturates)
module noc_credit_counter #(
  parameter int VC_DEPTH = 8,
  parameter int CW       = $clog2(VC_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          dec,
  input  logic          inc,
  output logic [CW-1:0] count,
  output logic          overflow
);

  logic full;

  assign full     = (count == CW'(VC_DEPTH));
  // A return that coincides with a send is balanced and therefore cannot overflow.
  assign overflow = inc && !dec && full;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= CW'(VC_DEPTH);
    end else if (inc && !dec) begin
      if (!full) count <= count + 1'b1;
    end else if (dec && !inc) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/noc_inject_arbiter.sv
// Injection-port arbiter: NUM_REQ requesters share one router injection port.
// Whole packets are granted round-robin and never interleaved. A VC is chosen
// per packet from the credit counters and written into the flit's VC field.
// Ports:
//   clk, reset  - clock, asynchronous active-high reset
//   i_flit_in   - per-requester flit: valid/head/tail at the MSBs, then VC, dest, payload
//   o_ready     - one-hot accept (combinational), forced low during reset
//   o_flit_out  - registered accepted flit; all zeros when nothing was accepted
//   i_credits   - per-VC credit-return pulse
//   o_err       - sticky: orphan body flit, head inside a packet, or credit overflow
//
// state      | meaning
// -----------+------------------------------------------------------------
// ARB_IDLE   | between packets; round-robin search for a head from rr_q
// ARB_LOCKED | packet in flight from lock_req_q on lock_vc_q until its tail
module noc_inject_arbiter
  import noc_flit_pkg::*;
#(
  parameter int WIDTH    = 128,
  parameter int N        = 16,
  parameter int NUM_VC   = 2,
  parameter int NUM_REQ  = 4,
  parameter int VC_DEPTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   i_flit_in [0:NUM_REQ-1],
  output logic [NUM_REQ-1:0] o_ready,
  output logic [WIDTH-1:0]   o_flit_out,
  input  logic [NUM_VC-1:0]  i_credits,
  output logic               o_err
);

  localparam int ADDRESS_WIDTH    = safe_clog2(N);
  localparam int VC_ADDRESS_WIDTH = safe_clog2(NUM_VC);
  localparam int RW               = safe_clog2(NUM_REQ);
  localparam int CW               = $clog2(VC_DEPTH + 1);
  localparam int POS_VALID        = WIDTH - FLIT_VALID_OFS;
  localparam int POS_HEAD         = WIDTH - FLIT_HEAD_OFS;
  localparam int POS_TAIL         = WIDTH - FLIT_TAIL_OFS;
  localparam int POS_VC           = WIDTH - FLIT_VC_OFS;
  localparam int POS_DEST         = POS_VC - VC_ADDRESS_WIDTH;
  localparam int POS_REST         = POS_DEST - ADDRESS_WIDTH;

  arb_state_e                  state_q, state_d;
  logic [RW-1:0]               rr_q, rr_d;
  logic [RW-1:0]               lock_req_q, lock_req_d;
  logic [VC_ADDRESS_WIDTH-1:0] lock_vc_q, lock_vc_d;

  logic [CW-1:0]               credit_cnt [NUM_VC];
  logic [NUM_VC-1:0]           credit_ok, credit_dec, credit_ovf;

  logic [NUM_REQ-1:0]          ready;
  logic                        send;
  logic [RW-1:0]               send_req;
  logic [VC_ADDRESS_WIDTH-1:0] send_vc;
  logic                        err_set;

  logic                        head_found, body_found;
  logic [RW-1:0]               head_idx, body_idx, cand;
  logic [VC_ADDRESS_WIDTH-1:0] low_vc;
  logic [WIDTH-1:0]            sel_flit, send_flit;

  function automatic logic [RW-1:0] next_req(input logic [RW-1:0] r);
    return (int'(r) == NUM_REQ - 1) ? '0 : r + 1'b1;
  endfunction

  function automatic logic [RW-1:0] rr_index(input logic [RW-1:0] base, input int off);
    int k;
    k = int'(base) + off;
    if (k >= NUM_REQ) k = k - NUM_REQ;
    return k[RW-1:0];
  endfunction

  for (genvar g = 0; g < NUM_VC; g++) begin : g_vc
    noc_credit_counter #(
      .VC_DEPTH (VC_DEPTH),
      .CW       (CW)
    ) u_credit (
      .clk      (clk),
      .reset    (reset),
      .dec      (credit_dec[g]),
      .inc      (i_credits[g]),
      .count    (credit_cnt[g]),
      .overflow (credit_ovf[g])
    );
    assign credit_ok[g]  = |credit_cnt[g];
    assign credit_dec[g] = send && (send_vc == VC_ADDRESS_WIDTH'(g));
  end

  // Candidate search: lowest VC with credit, first head at/after rr_q, and
  // lowest-index orphan body flit.
  always_comb begin
    head_found = 1'b0;
    head_idx   = '0;
    body_found = 1'b0;
    body_idx   = '0;
    low_vc     = '0;
    cand       = '0;
    for (int v = NUM_VC - 1; v >= 0; v--) begin
      if (credit_ok[v]) low_vc = VC_ADDRESS_WIDTH'(v);
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = rr_index(rr_q, i);
      if (!head_found && i_flit_in[cand][POS_VALID] && i_flit_in[cand][POS_HEAD]) begin
        head_found = 1'b1;
        head_idx   = cand;
      end
    end
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (i_flit_in[i][POS_VALID] && !i_flit_in[i][POS_HEAD]) begin
        body_found = 1'b1;
        body_idx   = RW'(i);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    lock_req_d = lock_req_q;
    lock_vc_d  = lock_vc_q;
    ready      = '0;
    send       = 1'b0;
    send_req   = '0;
    send_vc    = '0;
    err_set    = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (head_found && |credit_ok) begin
          send     = 1'b1;
          send_req = head_idx;
          send_vc  = low_vc;
          if (i_flit_in[head_idx][POS_TAIL]) begin
            rr_d = next_req(head_idx);
          end else begin
            state_d    = ARB_LOCKED;
            lock_req_d = head_idx;
            lock_vc_d  = low_vc;
          end
        end else if (body_found) begin
          // Orphan body: drain it so the requester cannot wedge the port.
          ready[body_idx] = 1'b1;
          err_set         = 1'b1;
        end
      end
      ARB_LOCKED: begin
        if (i_flit_in[lock_req_q][POS_VALID] && credit_ok[lock_vc_q]) begin
          send     = 1'b1;
          send_req = lock_req_q;
          send_vc  = lock_vc_q;
          // A second head inside a packet is forwarded as body but flagged.
          if (i_flit_in[lock_req_q][POS_HEAD]) err_set = 1'b1;
          if (i_flit_in[lock_req_q][POS_TAIL]) begin
            state_d = ARB_IDLE;
            rr_d    = next_req(lock_req_q);
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
    if (send) ready[send_req] = 1'b1;
    if (reset) begin
      ready   = '0;
      send    = 1'b0;
      err_set = 1'b0;
    end
  end

  assign o_ready  = ready;
  assign sel_flit = i_flit_in[send_req];
  assign send_flit = {sel_flit[WIDTH-1:POS_VC+1], send_vc,
                      sel_flit[POS_DEST -: ADDRESS_WIDTH], sel_flit[POS_REST:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ARB_IDLE;
      rr_q       <= '0;
      lock_req_q <= '0;
      lock_vc_q  <= '0;
      o_flit_out <= '0;
      o_err      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      lock_req_q <= lock_req_d;
      lock_vc_q  <= lock_vc_d;
      o_flit_out <= send ? send_flit : '0;
      o_err      <= o_err | err_set | (|credit_ovf);
    end
  end

endmodule

// File: tb/tb_noc_inject_arbiter.sv
module tb_noc_inject_arbiter;

  logic         clk;
  logic         reset;
  logic [127:0] flit_in [0:3];
  logic [3:0]   ready;
  logic [127:0] flit_out;
  logic [1:0]   credits;
  logic         err;

  int n_checks = 0;
  int n_err    = 0;

  noc_inject_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .i_flit_in  (flit_in),
    .o_ready    (ready),
    .o_flit_out (flit_out),
    .i_credits  (credits),
    .o_err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // valid=127 head=126 tail=125 vc=124 dest=123:120 payload=31:0
  function automatic logic [127:0] mk(input bit v, input bit h, input bit t, input bit vc,
                                      input logic [3:0] dest, input logic [31:0] pl);
    logic [127:0] f;
    f = '0;
    f[127] = v; f[126] = h; f[125] = t; f[124] = vc;
    f[123:120] = dest; f[31:0] = pl;
    return f;
  endfunction

  function automatic logic [127:0] setvc(input logic [127:0] f, input bit vc);
    logic [127:0] r;
    r = f;
    r[124] = vc;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < 4; i++) flit_in[i] = '0;
    credits = 2'b00;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic pulse_credits(input logic [1:0] c, input int n);
    for (int i = 0; i < n; i++) begin
      credits = c;
      step();
    end
    credits = 2'b00;
  endtask

  logic [127:0] fl, acc;
  logic [127:0] r1 [0:2];
  logic [127:0] r2 [0:1];

  initial begin
    clear_inputs();
    reset = 1'b1;
    // Reset state, with a head presented: nothing may be accepted.
    flit_in[0] = mk(1, 1, 1, 0, 4'd1, 32'h1);
    step();
    #1;
    chk("rst_ready", ready, 4'b0000);
    chk("rst_out", flit_out, '0);
    chk("rst_err", err, 0);
    chk("rst_cred0", dut.credit_cnt[0], 8);
    chk("rst_cred1", dut.credit_cnt[1], 8);
    clear_inputs();
    step();
    reset = 1'b0;

    // 4-flit packet from req0, dest 4; incoming VC field 1 must become 0.
    for (int i = 0; i < 4; i++) begin
      fl = mk(1, i == 0, i == 3, 1, 4'd4, 32'hA000 + i);
      flit_in[0] = fl;
      #1 chk("p4_ready", ready, 4'b0001);
      step();
      chk("p4_out", flit_out, setvc(fl, 0));
    end
    flit_in[0] = '0;
    chk("p4_cred0", dut.credit_cnt[0], 4);
    chk("p4_cred1", dut.credit_cnt[1], 8);
    step();
    chk("p4_idle_out", flit_out, '0);
    pulse_credits(2'b01, 4);
    chk("p4_restore", dut.credit_cnt[0], 8);

    // req1 and req2 heads together with rr=0: req1's packet first, complete.
    do_reset();
    r1[0] = mk(1, 1, 0, 1, 4'd7, 32'h100);
    r1[1] = mk(1, 0, 0, 1, 4'd7, 32'h101);
    r1[2] = mk(1, 0, 1, 1, 4'd7, 32'h102);
    r2[0] = mk(1, 1, 0, 0, 4'd9, 32'h200);
    r2[1] = mk(1, 0, 1, 0, 4'd9, 32'h201);
    for (int t = 0; t < 5; t++) begin
      flit_in[1] = (t < 3) ? r1[t] : '0;
      flit_in[2] = (t < 3) ? r2[0] : r2[t-3];
      #1 chk("rr_ready", ready, (t < 3) ? 4'b0010 : 4'b0100);
      acc = (t < 3) ? r1[t] : r2[t-3];
      step();
      chk("rr_out", flit_out, setvc(acc, 0));
    end
    clear_inputs();
    chk("rr_cred0", dut.credit_cnt[0], 3);

    // Credit return and send on VC0 in the same cycle at count 3.
    fl = mk(1, 1, 1, 0, 4'd2, 32'h300);
    flit_in[3] = fl;
    credits = 2'b01;
    #1 chk("same_ready", ready, 4'b1000);
    step();
    clear_inputs();
    chk("same_cred0", dut.credit_cnt[0], 3);
    chk("same_out", flit_out, fl);

    // Refill, then one extra pulse at full count: saturate and flag.
    pulse_credits(2'b01, 5);
    chk("sat_full", dut.credit_cnt[0], 8);
    chk("sat_err_before", err, 0);
    pulse_credits(2'b01, 1);
    chk("sat_cnt", dut.credit_cnt[0], 8);
    chk("sat_err", err, 1);
    do_reset();
    chk("sat_err_cleared", err, 0);

    // 10-flit packet without credit return: 8 go, then one per credit pulse.
    for (int i = 0; i < 8; i++) begin
      fl = mk(1, i == 0, 0, 0, 4'd5, 32'h400 + i);
      flit_in[0] = fl;
      #1 chk("nc_ready", ready, 4'b0001);
      step();
      chk("nc_out", flit_out, fl);
    end
    flit_in[0] = mk(1, 0, 0, 0, 4'd5, 32'h408);
    #1 chk("nc_stall", ready, 4'b0000);
    step();
    chk("nc_stall_out", flit_out, '0);
    for (int j = 8; j < 10; j++) begin
      fl = mk(1, 0, j == 9, 0, 4'd5, 32'h400 + j);
      flit_in[0] = fl;
      credits = 2'b01;
      #1 chk("nc_pulse_ready", ready, 4'b0000);
      step();
      credits = 2'b00;
      #1 chk("nc_release", ready, 4'b0001);
      step();
      chk("nc_rel_out", flit_out, fl);
    end
    flit_in[0] = '0;
    chk("nc_cred0", dut.credit_cnt[0], 0);
    // VC0 empty: a new head from req1 (rr=1) goes out on VC1.
    fl = mk(1, 1, 1, 0, 4'd2, 32'h77);
    flit_in[1] = fl;
    #1 chk("vc1_ready", ready, 4'b0010);
    step();
    flit_in[1] = '0;
    chk("vc1_out", flit_out, setvc(fl, 1));
    chk("vc1_cred1", dut.credit_cnt[1], 7);
    pulse_credits(2'b11, 1);
    pulse_credits(2'b01, 7);
    chk("nc_restore0", dut.credit_cnt[0], 8);
    chk("nc_restore1", dut.credit_cnt[1], 8);
    chk("nc_err", err, 0);

    // Orphan body flit in IDLE: consumed, not forwarded, sticky error.
    flit_in[2] = mk(1, 0, 0, 0, 4'd3, 32'h500);
    #1 chk("orph_ready", ready, 4'b0100);
    step();
    flit_in[2] = '0;
    chk("orph_out", flit_out, '0);
    chk("orph_err", err, 1);
    step();
    step();
    chk("orph_err_sticky", err, 1);
    do_reset();

    // Reset after the 2nd flit of a 4-flit packet, then req3 gets a packet.
    for (int i = 0; i < 2; i++) begin
      fl = mk(1, i == 0, 0, 0, 4'd6, 32'h600 + i);
      flit_in[0] = fl;
      #1 chk("mid_ready", ready, 4'b0001);
      step();
      chk("mid_out", flit_out, fl);
    end
    flit_in[0] = mk(1, 0, 0, 0, 4'd6, 32'h602);
    reset = 1'b1;
    #1;
    chk("mid_rst_out", flit_out, '0);
    chk("mid_rst_ready", ready, 4'b0000);
    chk("mid_rst_cred0", dut.credit_cnt[0], 8);
    step();
    flit_in[0] = '0;
    step();
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      fl = mk(1, i == 0, i == 1, 1, 4'd8, 32'h700 + i);
      flit_in[3] = fl;
      #1 chk("post_ready", ready, 4'b1000);
      step();
      chk("post_out", flit_out, setvc(fl, 0));
    end
    flit_in[3] = '0;
    chk("post_err", err, 0);

    // Head inside a locked packet: forwarded as body, flagged; others wait.
    fl = mk(1, 1, 0, 0, 4'd1, 32'h800);
    flit_in[1] = fl;
    #1 chk("dh_ready0", ready, 4'b0010);
    step();
    chk("dh_out0", flit_out, fl);
    flit_in[0] = mk(1, 1, 1, 0, 4'd2, 32'h900);
    fl = mk(1, 1, 0, 0, 4'd1, 32'h801);
    flit_in[1] = fl;
    #1 chk("dh_ready1", ready, 4'b0010);
    step();
    chk("dh_out1", flit_out, fl);
    chk("dh_err", err, 1);
    fl = mk(1, 0, 1, 0, 4'd1, 32'h802);
    flit_in[1] = fl;
    #1 chk("dh_ready2", ready, 4'b0010);
    step();
    chk("dh_out2", flit_out, fl);
    flit_in[1] = '0;
    #1 chk("dh_next", ready, 4'b0001);
    step();
    chk("dh_next_out", flit_out, mk(1, 1, 1, 0, 4'd2, 32'h900));
    clear_inputs();
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
